mux_41: RTL and testbench

Four-input, parameter-width multiplexer with a 2-bit select, usable as a generic datapath selector. The primary output `Y` is purely combinational so that select and data changes show up without a clock. An optional registered copy of the output and a select-change counter support timing closure and debug when the block sits in a clocked pipeline. The clock and reset affect only that optional register path.

---
 rtl/mux_41.sv | 71 +++++++
 tb/tb_mux_41.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_41.sv
// Four-input WIDTH-bit multiplexer with combinational output Y.
// Define MUX41_REG_OUT_EN to add the registered Y_q copy and the saturating select-change counter.
module mux_41 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic [WIDTH-1:0] D4,
  input  logic [1:0]       S,
  input  logic             en,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic [CNT_W-1:0] sel_cnt
);

  logic [WIDTH-1:0] y_s;

  // Data select; an unknown select drives all-X rather than falling back to an input
  always_comb begin
    y_s = {WIDTH{1'bx}};
    case (S)
      2'b00:   y_s = D1;
      2'b01:   y_s = D2;
      2'b10:   y_s = D3;
      2'b11:   y_s = D4;
      default: y_s = {WIDTH{1'bx}};
    endcase
  end

  assign Y = y_s;

`ifdef MUX41_REG_OUT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       s_prev_r;
  logic [WIDTH-1:0] y_q_r;
  logic [CNT_W-1:0] sel_cnt_r;

  // Output register, previous-select tracker and saturating change counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q_r     <= {WIDTH{1'b0}};
      s_prev_r  <= 2'b00;
      sel_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (en) begin
        y_q_r <= y_s;
      end
      s_prev_r <= S;
      if ((S != s_prev_r) && (sel_cnt_r != CNT_MAX)) begin
        sel_cnt_r <= sel_cnt_r + CNT_W'(1);
      end
    end
  end

  assign Y_q     = y_q_r;
  assign sel_cnt = sel_cnt_r;
`else
  logic unused_s;

  // Without the register stage the clocked inputs have no load
  assign unused_s = &{1'b0, clk, rst_n, en};
  assign Y_q      = y_s;
  assign sel_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mux_41.sv
// Self-checking bench for mux_41: directed cases then randomized traffic against a
// behavioural model (array lookup for Y, integer register/counter model for Y_q and sel_cnt).
module tb_mux_41;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] d_arr [4];
  logic [1:0]       s;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] sel_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_yq   = 0;
  int m_cnt  = 0;
  int m_prev = 0;

  mux_41 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .D1      (d_arr[0]),
    .D2      (d_arr[1]),
    .D3      (d_arr[2]),
    .D4      (d_arr[3]),
    .S       (s),
    .en      (en),
    .Y       (y),
    .Y_q     (y_q),
    .sel_cnt (sel_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, update the model, compare the clocked outputs
  task automatic clock_edge(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      m_yq   = 0;
      m_cnt  = 0;
      m_prev = 0;
    end else begin
      if (en) m_yq = int'(d_arr[s]);
      if ((int'(s) != m_prev) && (m_cnt < CNT_MAX)) m_cnt = m_cnt + 1;
      m_prev = int'(s);
    end
    #1;
`ifdef MUX41_REG_OUT_EN
    check({tag, ".y_q"}, 32'(y_q), 32'(m_yq));
    check({tag, ".cnt"}, 32'(sel_cnt), 32'(m_cnt));
`else
    check({tag, ".y_q"}, 32'(y_q), 32'(d_arr[s]));
    check({tag, ".cnt"}, 32'(sel_cnt), 32'd0);
`endif
    @(negedge clk);
  endtask

  // Inputs already driven: check Y combinationally, then clock once
  task automatic step(input string tag);
    #1;
    check({tag, ".y"}, 32'(y), 32'(d_arr[s]));
    clock_edge(tag);
  endtask

  task automatic set_d(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] e);
    d_arr[0] = a;
    d_arr[1] = b;
    d_arr[2] = c;
    d_arr[3] = e;
  endtask

  initial begin
    logic [WIDTH-1:0] pat_a [4];
    logic [WIDTH-1:0] pat_b [4];
    logic [WIDTH-1:0] hold_v;
    int               seq_exp [5];
    int               seq_s [5];

    pat_a   = '{8'h01, 8'h00, 8'h00, 8'h01};
    pat_b   = '{8'h00, 8'h01, 8'h00, 8'h01};
    seq_exp = '{1, 2, 3, 3, 3};
    seq_s   = '{1, 2, 3, 0, 1};

    rst_n = 1'b0;
    en    = 1'b0;
    s     = 2'b00;
    set_d(8'h00, 8'h00, 8'h00, 8'h00);

    // Pattern 1,0,0,1 and 0,1,0,1 across every select value, checked against constants too
    for (int i = 0; i < 4; i++) begin
      set_d(pat_a[0], pat_a[1], pat_a[2], pat_a[3]);
      s = 2'(i);
      #1;
      check("pat_a.const", 32'(y), 32'(pat_a[i]));
      step("pat_a");
    end
    for (int i = 0; i < 4; i++) begin
      set_d(pat_b[0], pat_b[1], pat_b[2], pat_b[3]);
      s = 2'(i);
      #1;
      check("pat_b.const", 32'(y), 32'(pat_b[i]));
      step("pat_b");
    end

    // Wide data, select 10, Y unaffected by reset toggling
    rst_n = 1'b1;
    set_d(8'hA5, 8'h3C, 8'hFF, 8'h00);
    s = 2'b10;
    #1;
    check("wide.y", 32'(y), 32'h0000_00FF);
    step("wide");
    rst_n = 1'b0;
    #1;
    check("wide.rst_y", 32'(y), 32'h0000_00FF);
    step("wide_rst");

    // Reset for two cycles, then load through D2
    rst_n = 1'b0;
    en    = 1'b1;
    step("rst1");
    step("rst2");
`ifdef MUX41_REG_OUT_EN
    check("rst.y_q0", 32'(y_q), 32'd0);
    check("rst.cnt0", 32'(sel_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    en    = 1'b1;
    s     = 2'b01;
    set_d(8'h00, 8'h01, 8'h00, 8'h00);
    step("load");
    check("load.y_q1", 32'(y_q), 32'd1);

    // Hold with en low while D2 changes
    en     = 1'b0;
    hold_v = y_q;
    d_arr[1] = 8'h5A;
    step("hold");
    check("hold.y", 32'(y), 32'h0000_005A);
`ifdef MUX41_REG_OUT_EN
    check("hold.y_q", 32'(y_q), 32'(hold_v));
`endif

    // Counter saturation from a fresh reset
    rst_n = 1'b0;
    s     = 2'b00;
    step("sat_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s = 2'(seq_s[i]);
      step("sat");
`ifdef MUX41_REG_OUT_EN
      check("sat.const", 32'(sel_cnt), 32'(seq_exp[i]));
`endif
    end
    s = 2'b01;
    step("sat_same");
    rst_n = 1'b0;
    step("sat_clr");
`ifdef MUX41_REG_OUT_EN
    check("sat.clr", 32'(sel_cnt), 32'd0);
`endif

    // Randomized traffic, including sporadic resets
    for (int i = 0; i < 300; i++) begin
      set_d(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
      s     = 2'($urandom_range(0, 3));
      en    = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 19) != 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
